// File: rtl/mem_write_checker_if.sv
// Store-port tap bundle for mem_write_checker.
// Carries the data-memory write strobe, the store address (ALUResult)
// and the store data (WriteData) from the core side to the checker.
//   master : the core / stimulus side, drives all three signals
//   slave  : the checker side, observes all three signals
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (output mem_write, addr, wdata);
  modport slave  (input  mem_write, addr, wdata);
endinterface

// File: rtl/mem_write_checker.sv
// Ordered store checker for the data-memory write port.
// After a start pulse it watches the store tap and expects NUM_CHECKS
// stores, in order, matching the (exp_addr, exp_data) list. It ends in
// PASS when the last expected store is seen, or in FAIL on a data
// mismatch, an out-of-order address (STRICT=1 only) or a timeout.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       one-cycle arm pulse, honoured in IDLE, PASS and FAIL
//   bus         store tap (mem_write, addr, wdata), slave side
//   exp_addr    flattened expected addresses, entry 0 in the LSBs
//   exp_data    flattened expected data, same ordering
//   busy        high in RUN
//   done        high in PASS or FAIL
//   pass        high in PASS
//   fail_code   00 none, 01 data, 10 address, 11 timeout
//   match_count expected stores matched so far
//   cycle_count RUN cycles elapsed, saturating at TIMEOUT
//   err_addr    store address captured on a mismatch failure
//   err_data    store data captured on a mismatch failure
module mem_write_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 1024,
  parameter int STRICT     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  mem_write_checker_if.slave               bus,
  input  logic [NUM_CHECKS*ADDR_W-1:0]     exp_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0]     exp_data,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [1:0]                       fail_code,
  output logic [$clog2(NUM_CHECKS+1)-1:0]  match_count,
  output logic [$clog2(TIMEOUT+1)-1:0]     cycle_count,
  output logic [ADDR_W-1:0]                err_addr,
  output logic [DATA_W-1:0]                err_data
);
  localparam int MC_W = $clog2(NUM_CHECKS+1);
  localparam int CC_W = $clog2(TIMEOUT+1);

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_DATA    = 2'b01;
  localparam logic [1:0] FC_ADDR    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t            state_reg;
  logic [1:0]        fail_code_reg;
  logic [MC_W-1:0]   match_count_reg;
  logic [CC_W-1:0]   cycle_count_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic [DATA_W-1:0] err_data_reg;

  // Per-entry comparators; the entry under test is then picked by
  // match_count so only the next expected pair can ever match.
  logic [NUM_CHECKS-1:0] addr_hit;
  logic [NUM_CHECKS-1:0] data_hit;

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
    assign addr_hit[gi] = (bus.addr  == exp_addr[gi*ADDR_W +: ADDR_W]);
    assign data_hit[gi] = (bus.wdata == exp_data[gi*DATA_W +: DATA_W]);
  end

  logic cur_addr_hit;
  logic cur_data_hit;

  always_comb begin
    cur_addr_hit = 1'b0;
    cur_data_hit = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (match_count_reg == MC_W'(i)) begin
        cur_addr_hit = addr_hit[i];
        cur_data_hit = data_hit[i];
      end
    end
  end

  logic store_ok;
  logic last_idx;
  logic timeout_hit;

  assign store_ok    = bus.mem_write && cur_addr_hit && cur_data_hit;
  assign last_idx    = (match_count_reg == MC_W'(NUM_CHECKS-1));
  assign timeout_hit = (cycle_count_reg == CC_W'(TIMEOUT-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      fail_code_reg   <= FC_NONE;
      match_count_reg <= '0;
      cycle_count_reg <= '0;
      err_addr_reg    <= '0;
      err_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, PASS, FAIL: begin
          // Terminal states hold everything until re-armed.
          if (start) begin
            state_reg       <= RUN;
            fail_code_reg   <= FC_NONE;
            match_count_reg <= '0;
            cycle_count_reg <= '0;
            err_addr_reg    <= '0;
            err_data_reg    <= '0;
          end
        end
        RUN: begin
          if (cycle_count_reg != CC_W'(TIMEOUT))
            cycle_count_reg <= cycle_count_reg + CC_W'(1);
          if (store_ok) begin
            match_count_reg <= match_count_reg + MC_W'(1);
            // A final match beats a coincident timeout; an intermediate
            // match is not a transition, so the timeout still applies.
            if (last_idx) begin
              state_reg <= PASS;
            end else if (timeout_hit) begin
              state_reg     <= FAIL;
              fail_code_reg <= FC_TIMEOUT;
            end
          end else if (bus.mem_write && cur_addr_hit) begin
            state_reg     <= FAIL;
            fail_code_reg <= FC_DATA;
            err_addr_reg  <= bus.addr;
            err_data_reg  <= bus.wdata;
          end else if (bus.mem_write && (STRICT != 0)) begin
            state_reg     <= FAIL;
            fail_code_reg <= FC_ADDR;
            err_addr_reg  <= bus.addr;
            err_data_reg  <= bus.wdata;
          end else if (timeout_hit) begin
            state_reg     <= FAIL;
            fail_code_reg <= FC_TIMEOUT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == PASS) || (state_reg == FAIL);
  assign pass        = (state_reg == PASS);
  assign fail_code   = fail_code_reg;
  assign match_count = match_count_reg;
  assign cycle_count = cycle_count_reg;
  assign err_addr    = err_addr_reg;
  assign err_data    = err_data_reg;
endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a STRICT=1 and a STRICT=0 instance share
// the same store stimulus. Expected terminal results are queued per
// instance when a test is issued; a monitor pops and compares whenever
// an instance raises done.
module tb_mem_write_checker;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mw = 1'b0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] d = '0;

  logic [NC*AW-1:0] exp_addr = {32'd104, 32'd100};
  logic [NC*DW-1:0] exp_data = {32'd10, 32'd7};

  always #5 clk = ~clk;

  mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();
  mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_n ();
  assign bus_s.mem_write = mw;
  assign bus_s.addr      = a;
  assign bus_s.wdata     = d;
  assign bus_n.mem_write = mw;
  assign bus_n.addr      = a;
  assign bus_n.wdata     = d;

  logic busy_s, done_s, pass_s, busy_n, done_n, pass_n;
  logic [1:0] fc_s, fc_n, mc_s, mc_n;
  logic [4:0] cc_s, cc_n;
  logic [AW-1:0] ea_s, ea_n;
  logic [DW-1:0] ed_s, ed_n;

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .TIMEOUT(TO), .STRICT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus_s),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(fc_s),
    .match_count(mc_s), .cycle_count(cc_s), .err_addr(ea_s), .err_data(ed_s)
  );

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .TIMEOUT(TO), .STRICT(0)) u_dut_n (
    .clk(clk), .reset(reset), .start(start), .bus(bus_n),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy_n), .done(done_n), .pass(pass_n), .fail_code(fc_n),
    .match_count(mc_n), .cycle_count(cc_n), .err_addr(ea_n), .err_data(ed_n)
  );

  typedef struct {
    logic          p;
    logic [1:0]    fc;
    logic [1:0]    mc;
    logic [4:0]    cc;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } exp_t;

  exp_t q_s[$];
  exp_t q_n[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [1:0] fc, input logic [1:0] mc,
                              input logic [4:0] cc, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    exp_t e;
    e.p = p; e.fc = fc; e.mc = mc; e.cc = cc; e.ea = ea; e.ed = ed;
    return e;
  endfunction

  task automatic compare(input string who, input exp_t e, input logic p, input logic [1:0] fc,
                         input logic [1:0] mc, input logic [4:0] cc,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    $display("done %s pass=%0d fail_code=%0d match=%0d cycles=%0d err_addr=%0d err_data=%0d",
             who, p, fc, mc, cc, ea, ed);
    check({who, " pass"}, p, e.p);
    check({who, " fail_code"}, fc, e.fc);
    check({who, " match_count"}, mc, e.mc);
    check({who, " cycle_count"}, cc, e.cc);
    check({who, " err_addr"}, ea, e.ea);
    check({who, " err_data"}, ed, e.ed);
  endtask

  // Monitor: one scoreboard pop per rising done of each instance.
  logic prev_s = 1'b0;
  logic prev_n = 1'b0;
  always @(negedge clk) begin
    if (done_s && !prev_s) begin
      check("strict expected_pending", q_s.size() > 0, 1);
      if (q_s.size() > 0) compare("strict", q_s.pop_front(), pass_s, fc_s, mc_s, cc_s, ea_s, ed_s);
    end
    if (done_n && !prev_n) begin
      check("lenient expected_pending", q_n.size() > 0, 1);
      if (q_n.size() > 0) compare("lenient", q_n.pop_front(), pass_n, fc_n, mc_n, cc_n, ea_n, ed_n);
    end
    prev_s = done_s;
    prev_n = done_n;
  end

  // Stimulus tasks assume they are entered right after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    mw = 1'b1; a = sa; d = sd;
    @(negedge clk);
    mw = 1'b0; a = '0; d = '0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " armed busy"}, busy_s, 1);
    check({tag, " armed match_count"}, mc_s, 0);
    check({tag, " armed cycle_count"}, cc_s, 0);
    check({tag, " armed fail_code"}, fc_s, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #12;
    check("reset busy", busy_s, 0);
    check("reset done", done_s, 0);
    check("reset match_count", mc_s, 0);
    check("reset cycle_count", cc_s, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // Two in-order stores, three cycles apart
    q_s.push_back(mk(1, 2'b00, 2, 4, 0, 0));
    q_n.push_back(mk(1, 2'b00, 2, 4, 0, 0));
    do_start("pass");
    store(100, 7);
    idle(2);
    store(104, 10);
    check("pass done", done_s, 1);
    idle(1);

    // Re-arm from PASS and replay with identical timing
    q_s.push_back(mk(1, 2'b00, 2, 4, 0, 0));
    q_n.push_back(mk(1, 2'b00, 2, 4, 0, 0));
    do_start("replay");
    store(100, 7);
    idle(2);
    store(104, 10);
    idle(1);

    // Data mismatch on the first expected address
    q_s.push_back(mk(0, 2'b01, 0, 1, 100, 9));
    q_n.push_back(mk(0, 2'b01, 0, 1, 100, 9));
    do_start("data");
    store(100, 9);
    idle(1);

    // Wrong address: strict fails, lenient ignores it
    q_s.push_back(mk(0, 2'b10, 0, 1, 96, 7));
    do_start("addr");
    store(96, 7);
    store(100, 7);
    check("lenient match_count after ignore", mc_n, 1);
    check("lenient busy after ignore", busy_n, 1);
    q_n.push_back(mk(1, 2'b00, 2, 3, 0, 0));
    store(104, 10);
    idle(1);

    // Timeout with no stores: busy for exactly TO cycles
    q_s.push_back(mk(0, 2'b11, 0, 16, 0, 0));
    q_n.push_back(mk(0, 2'b11, 0, 16, 0, 0));
    do_start("timeout");
    n = 0;
    while (busy_s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout busy_cycles", n, 16);
    idle(1);

    // Final store on the last allowed cycle wins over the timeout
    q_s.push_back(mk(1, 2'b00, 2, 16, 0, 0));
    q_n.push_back(mk(1, 2'b00, 2, 16, 0, 0));
    do_start("edge");
    store(100, 7);
    idle(14);
    store(104, 10);
    idle(1);

    // Asynchronous reset mid-RUN, between edges
    do_start("areset");
    store(100, 7);
    check("areset pre match_count", mc_s, 1);
    #2 reset = 1'b0;
    #1;
    check("areset busy", busy_s, 0);
    check("areset done", done_s, 0);
    check("areset pass", pass_s, 0);
    check("areset fail_code", fc_s, 0);
    check("areset match_count", mc_s, 0);
    check("areset cycle_count", cc_s, 0);
    check("areset err_addr", ea_s, 0);
    check("areset err_data", ed_s, 0);
    check("areset lenient match_count", mc_n, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    store(100, 7);
    store(104, 10);
    idle(1);
    check("post-reset busy", busy_s, 0);
    check("post-reset done", done_s, 0);
    check("post-reset match_count", mc_s, 0);
    check("post-reset cycle_count", cc_s, 0);

    check("strict queue drained", q_s.size(), 0);
    check("lenient queue drained", q_n.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
